// File: rtl/axi_wr_burst_master.sv
// rtl/axi_wr_burst_master.sv - AXI4 write burst master with a buffered write-data FIFO
// One burst at a time: AW and W are issued together, then the B response is collected and reported.
module axi_wr_burst_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [ID_WIDTH-1:0]     cmd_id,
   input  logic [7:0]              cmd_len,
   input  logic [2:0]              cmd_size,
   input  logic [1:0]              cmd_burst,
   input  logic                    wr_data_valid,
   output logic                    wr_data_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [ID_WIDTH-1:0]     awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awlock,
   output logic [3:0]              awcache,
   output logic [2:0]              awprot,
   output logic [3:0]              awqos,
   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   input  logic                    bvalid,
   output logic                    bready,
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   output logic                    done_valid,
   output logic [ID_WIDTH-1:0]     done_id,
   output logic [1:0]              done_resp,
   output logic                    done_id_err,
   output logic                    busy,
   output logic [LW-1:0]           fifo_level
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [2:0]    MAX_SIZE   = 3'($clog2(SW));
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

   state_t                state_q;
   logic                  cmd_ready_q;
   logic                  awvalid_q;
   logic                  aw_done_q;
   logic                  bready_q;
   logic                  done_valid_q;
   logic                  done_id_err_q;
   logic [ID_WIDTH-1:0]   done_id_q;
   logic [1:0]            done_resp_q;
   logic [ID_WIDTH-1:0]   awid_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [7:0]            awlen_q;
   logic [2:0]            awsize_q;
   logic [1:0]            awburst_q;
   logic [8:0]            beats_q;

   logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
   logic [SW-1:0]         strb_mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [LW-1:0]         level_q;
   logic [LW-1:0]         level_d;

   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;
   logic w_left;
   logic last_beat;
   logic aw_hs;
   logic aw_ok;
   logic w_ok;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == FULL_LEVEL);
   assign push       = wr_data_valid && !fifo_full;
   assign w_left     = (state_q == BURST) && (beats_q <= {1'b0, awlen_q});
   assign last_beat  = (beats_q == {1'b0, awlen_q});
   assign pop        = wvalid && wready;
   assign aw_hs      = awvalid_q && awready;
   assign aw_ok      = aw_done_q || aw_hs;
   assign w_ok       = !w_left || (pop && last_beat);

   // Head payload is gated by wvalid so W outputs read as zero whenever no beat is offered.
   assign wvalid        = w_left && !fifo_empty;
   assign wlast         = wvalid && last_beat;
   assign wdata         = wvalid ? data_mem_q[rd_ptr_q] : '0;
   assign wstrb         = wvalid ? strb_mem_q[rd_ptr_q] : '0;
   assign wr_data_ready = !fifo_full;
   assign fifo_level    = level_q;

   assign cmd_ready   = cmd_ready_q;
   assign awvalid     = awvalid_q;
   assign awid        = awid_q;
   assign awaddr      = awaddr_q;
   assign awlen       = awlen_q;
   assign awsize      = awsize_q;
   assign awburst     = awburst_q;
   assign awlock      = 1'b0;
   assign awcache     = 4'd0;
   assign awprot      = 3'd0;
   assign awqos       = 4'd0;
   assign bready      = bready_q;
   assign done_valid  = done_valid_q;
   assign done_id     = done_id_q;
   assign done_resp   = done_resp_q;
   assign done_id_err = done_id_err_q;
   assign busy        = (state_q != IDLE);

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (push) begin
         data_mem_q[wr_ptr_q] <= wr_data;
         strb_mem_q[wr_ptr_q] <= wr_strb;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         awvalid_q     <= 1'b0;
         aw_done_q     <= 1'b0;
         bready_q      <= 1'b0;
         done_valid_q  <= 1'b0;
         done_id_err_q <= 1'b0;
         done_id_q     <= '0;
         done_resp_q   <= 2'b00;
         awid_q        <= '0;
         awaddr_q      <= '0;
         awlen_q       <= 8'd0;
         awsize_q      <= 3'd0;
         awburst_q     <= 2'b00;
         beats_q       <= 9'd0;
      end else begin
         done_valid_q <= 1'b0;
         if (pop) beats_q <= beats_q + 9'd1;
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  if (cmd_size > MAX_SIZE) begin
                     // Oversized beat cannot be carried on this bus: report SLVERR without touching AXI.
                     done_valid_q  <= 1'b1;
                     done_resp_q   <= 2'b10;
                     done_id_q     <= cmd_id;
                     done_id_err_q <= 1'b0;
                  end else begin
                     awid_q      <= cmd_id;
                     awaddr_q    <= cmd_addr;
                     awlen_q     <= cmd_len;
                     awsize_q    <= cmd_size;
                     awburst_q   <= cmd_burst;
                     beats_q     <= 9'd0;
                     aw_done_q   <= 1'b0;
                     awvalid_q   <= 1'b1;
                     cmd_ready_q <= 1'b0;
                     state_q     <= BURST;
                  end
               end
            end
            BURST: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (aw_ok && w_ok) begin
                  bready_q <= 1'b1;
                  state_q  <= RESP;
               end
            end
            RESP: begin
               if (bvalid && bready_q) begin
                  bready_q      <= 1'b0;
                  done_valid_q  <= 1'b1;
                  done_resp_q   <= bresp;
                  done_id_q     <= bid;
                  done_id_err_q <= (bid != awid_q);
                  cmd_ready_q   <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// tb/tb_axi_wr_burst_master.sv - self-checking bench for axi_wr_burst_master
// A queue of pushed beats is the reference; every W beat, AW payload and completion is checked against it.
module tb_axi_wr_burst_master;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int IW    = 4;
   localparam int DEPTH = 16;
   localparam int LW    = 5;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_addr = '0;
   logic [IW-1:0]   cmd_id = '0;
   logic [7:0]      cmd_len = '0;
   logic [2:0]      cmd_size = '0;
   logic [1:0]      cmd_burst = '0;
   logic            wr_data_valid = 1'b0;
   logic            wr_data_ready;
   logic [DW-1:0]   wr_data = '0;
   logic [DW/8-1:0] wr_strb = '0;
   logic            awvalid;
   logic            awready = 1'b0;
   logic [IW-1:0]   awid;
   logic [AW-1:0]   awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic [3:0]      awqos;
   logic            wvalid;
   logic            wready = 1'b0;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;
   logic            bvalid = 1'b0;
   logic            bready;
   logic [IW-1:0]   bid = '0;
   logic [1:0]      bresp = '0;
   logic            done_valid;
   logic [IW-1:0]   done_id;
   logic [1:0]      done_resp;
   logic            done_id_err;
   logic            busy;
   logic [LW-1:0]   fifo_level;

   axi_wr_burst_master dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_id(cmd_id),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data), .wr_strb(wr_strb),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp), .done_id_err(done_id_err),
      .busy(busy), .fifo_level(fifo_level)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [DW-1:0]   d;
      logic [DW/8-1:0] s;
   } beat_t;

   beat_t model[$];

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int push_budget = 0;
   int wr_prob = 0;
   int aw_prob = 100;
   int w_prob = 100;
   bit manual_ready = 1'b0;

   int beat_idx = 0;
   int cur_len = 0;
   bit in_burst = 1'b0;
   bit aw_seen = 1'b0;
   bit prev_stall = 1'b0;
   logic [DW-1:0]   prev_data = '0;
   logic [DW/8-1:0] prev_strb = '0;
   logic            prev_last = 1'b0;
   logic [IW+AW+8+3+2-1:0] exp_aw = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: beats leave in push order, beat k of a burst carries wlast iff k == len.
   always @(negedge aclk) begin
      if (!aresetn) begin
         model.delete();
         beat_idx   = 0;
         in_burst   = 1'b0;
         aw_seen    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         chk("fifo_level", 64'(fifo_level), 64'(model.size()));
         chk("wr_data_ready", 64'(wr_data_ready), 64'(model.size() < DEPTH));
         chk("wvalid_expect", 64'(wvalid), 64'(in_burst && beat_idx <= cur_len && model.size() > 0));
         if (prev_stall) begin
            chk("stall_wvalid", 64'(wvalid), 64'(1'b1));
            chk("stall_wdata", 64'(wdata), 64'(prev_data));
            chk("stall_wstrb", 64'(wstrb), 64'(prev_strb));
            chk("stall_wlast", 64'(wlast), 64'(prev_last));
         end
         if (awvalid) begin
            chk("aw_expected", 64'(in_burst && !aw_seen), 64'(1'b1));
            chk("aw_payload", 64'({awid, awaddr, awlen, awsize, awburst}), 64'(exp_aw));
            if (awready) aw_seen = 1'b1;
         end
         if (bready) chk("resp_order", 64'(aw_seen && beat_idx == cur_len + 1), 64'(1'b1));
         if (wvalid) begin
            chk("wlast", 64'(wlast), 64'(beat_idx == cur_len));
            if (wready && model.size() > 0) begin
               chk("wdata", 64'(wdata), 64'(model[0].d));
               chk("wstrb", 64'(wstrb), 64'(model[0].s));
               void'(model.pop_front());
               beat_idx++;
            end
         end
         if (cmd_valid && cmd_ready) begin
            in_burst = (cmd_size <= 3'd2);
            cur_len  = int'(cmd_len);
            beat_idx = 0;
            aw_seen  = 1'b0;
            exp_aw   = {cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst};
         end
         if (wr_data_valid && wr_data_ready) model.push_back('{d: wr_data, s: wr_strb});
         if (done_valid) done_cnt++;
         prev_stall = wvalid && !wready;
         prev_data  = wdata;
         prev_strb  = wstrb;
         prev_last  = wlast;
      end
   end

   task automatic step();
      bit acc;
      acc = wr_data_valid && wr_data_ready;
      @(posedge aclk);
      #1;
      if (acc) push_budget--;
      if (acc || !wr_data_valid) begin
         if (push_budget > 0 && $urandom_range(99) < wr_prob) begin
            wr_data_valid = 1'b1;
            wr_data       = $urandom;
            wr_strb       = 4'($urandom);
         end else begin
            wr_data_valid = 1'b0;
         end
      end
      if (!manual_ready) begin
         awready = ($urandom_range(99) < aw_prob);
         wready  = ($urandom_range(99) < w_prob);
      end
   endtask

   task automatic preload(input int n);
      int k;
      k = 0;
      push_budget = n;
      wr_prob = 100;
      while (push_budget > 0 && k < 200) begin
         step();
         k++;
      end
      chk("preload_wait", 64'(k < 200), 64'(1'b1));
      wr_prob = 0;
   endtask

   task automatic issue(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] l,
                        input logic [2:0] sz, input logic [1:0] bt);
      int k;
      k = 0;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_id    = id;
      cmd_len   = l;
      cmd_size  = sz;
      cmd_burst = bt;
      while (!cmd_ready && k < 100) begin
         step();
         k++;
      end
      chk("cmd_ready_wait", 64'(k < 100), 64'(1'b1));
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic resp_phase(input logic [IW-1:0] rbid, input logic [1:0] rbresp,
                             input logic [IW-1:0] cid, input int bdelay);
      int k;
      k = 0;
      while (!bready && k < 6000) begin
         step();
         k++;
      end
      chk("bready_wait", 64'(k < 6000), 64'(1'b1));
      for (int i = 0; i < bdelay; i++) begin
         step();
         chk("bready_hold", 64'(bready), 64'(1'b1));
      end
      bvalid = 1'b1;
      bid    = rbid;
      bresp  = rbresp;
      step();
      bvalid = 1'b0;
      exp_done++;
      chk("done_valid", 64'(done_valid), 64'(1'b1));
      chk("done_resp", 64'(done_resp), 64'(rbresp));
      chk("done_id", 64'(done_id), 64'(rbid));
      chk("done_id_err", 64'(done_id_err), 64'(rbid != cid));
      chk("bready_drop", 64'(bready), 64'(1'b0));
      chk("busy_after_done", 64'(busy), 64'(1'b0));
      step();
      chk("done_pulse", 64'(done_valid), 64'(1'b0));
      chk("done_resp_hold", 64'(done_resp), 64'(rbresp));
      chk("done_id_hold", 64'(done_id), 64'(rbid));
      chk("done_count", 64'(done_cnt), 64'(exp_done));
   endtask

   task automatic run_cmd(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] l,
                          input logic [2:0] sz, input logic [1:0] bt, input logic [IW-1:0] rbid,
                          input logic [1:0] rbresp, input int bdelay);
      issue(a, id, l, sz, bt);
      if (sz > 3'd2) begin
         exp_done++;
         chk("bad_size_done", 64'(done_valid), 64'(1'b1));
         chk("bad_size_resp", 64'(done_resp), 64'(2'b10));
         chk("bad_size_id", 64'(done_id), 64'(id));
         chk("bad_size_awvalid", 64'(awvalid), 64'(1'b0));
         chk("bad_size_busy", 64'(busy), 64'(1'b0));
         step();
         chk("bad_size_pulse", 64'(done_valid), 64'(1'b0));
         chk("bad_size_awvalid2", 64'(awvalid), 64'(1'b0));
         chk("done_count", 64'(done_cnt), 64'(exp_done));
      end else begin
         chk("busy_burst", 64'(busy), 64'(1'b1));
         chk("awvalid_rise", 64'(awvalid), 64'(1'b1));
         resp_phase(rbid, rbresp, id, bdelay);
      end
   endtask

   initial begin
      int k;
      logic [7:0] l;
      logic [2:0] sz;
      logic [IW-1:0] id;
      logic [IW-1:0] rb;

      // Reset state
      #2;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
      chk("rst_valids", 64'({awvalid, wvalid, wlast, bready, done_valid, busy}), 64'(6'd0));
      chk("rst_fifo_level", 64'(fifo_level), 64'(0));
      chk("rst_aw_payload", 64'({awid, awaddr, awlen, awsize, awburst}), 64'(0));
      chk("rst_tieoff", 64'({awlock, awcache, awprot, awqos}), 64'(0));
      chk("rst_done_payload", 64'({done_id, done_resp, done_id_err, wdata, wstrb}), 64'(0));
      @(posedge aclk);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      manual_ready = 1'b1;
      awready = 1'b1;
      wready  = 1'b1;
      step();
      chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1'b1));

      // Basic 4-beat burst
      preload(4);
      chk("preload4_level", 64'(fifo_level), 64'(4));
      run_cmd(32'h100, 4'd5, 8'd3, 3'd2, 2'b01, 4'd5, 2'b00, 0);
      chk("basic_beats", 64'(beat_idx), 64'(4));

      // AW held off past the end of W, with a W stall in the middle
      awready = 1'b0;
      wready  = 1'b0;
      preload(4);
      issue(32'h200, 4'd3, 8'd3, 3'd2, 2'b01);
      for (int c = 0; c < 6; c++) begin
         awready = 1'b0;
         wready  = (c != 1 && c != 2);
         chk("no_early_resp", 64'(bready), 64'(1'b0));
         chk("aw_held", 64'(awvalid), 64'(1'b1));
         step();
      end
      chk("w_before_aw", 64'({wvalid, awvalid, bready}), 64'(3'b010));
      awready = 1'b1;
      step();
      awready = 1'b0;
      chk("resp_after_aw", 64'({awvalid, bready}), 64'(2'b01));
      resp_phase(4'd3, 2'b00, 4'd3, 1);

      // Full FIFO with a simultaneous pop
      awready = 1'b1;
      wready  = 1'b0;
      push_budget = 20;
      wr_prob = 100;
      k = 0;
      while (fifo_level != LW'(DEPTH) && k < 100) begin
         step();
         k++;
      end
      chk("fill_wait", 64'(k < 100), 64'(1'b1));
      chk("full_ready", 64'(wr_data_ready), 64'(1'b0));
      chk("full_level", 64'(fifo_level), 64'(16));
      wready = 1'b1;
      issue(32'h300, 4'd7, 8'd3, 3'd2, 2'b01);
      chk("full_pop_ready", 64'({wvalid, wr_data_ready, wr_data_valid}), 64'(3'b101));
      step();
      chk("refused_level", 64'(fifo_level), 64'(15));
      chk("slot_visible", 64'(wr_data_ready), 64'(1'b1));
      step();
      chk("push_pop_level", 64'(fifo_level), 64'(15));
      wr_prob = 0;
      push_budget = wr_data_valid ? 1 : 0;
      resp_phase(4'd7, 2'b01, 4'd7, 0);

      // Oversized beat, then an ID mismatch on B
      run_cmd(32'h400, 4'd9, 8'd0, 3'd3, 2'b01, 4'd9, 2'b00, 0);
      run_cmd(32'h500, 4'd5, 8'd1, 3'd2, 2'b01, 4'd6, 2'b10, 2);

      // Randomized bursts against the queue model
      manual_ready = 1'b0;
      aw_prob = 60;
      w_prob  = 70;
      wr_prob = 75;
      for (int i = 0; i < 20; i++) begin
         l  = (i == 10) ? 8'd255 : 8'($urandom_range(0, 15));
         sz = (i % 7 == 3) ? 3'd3 : 3'($urandom_range(0, 2));
         id = 4'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : id;
         if (sz <= 3'd2) push_budget += int'(l) + 1;
         run_cmd($urandom, id, l, sz, 2'($urandom_range(0, 2)), rb, 2'($urandom), $urandom_range(0, 3));
      end

      // Reset in the middle of a burst
      push_budget += 8;
      issue(32'h600, 4'd2, 8'd7, 3'd2, 2'b01);
      step();
      step();
      #1 aresetn = 1'b0;
      cmd_valid = 1'b0;
      wr_data_valid = 1'b0;
      push_budget = 0;
      wr_prob = 0;
      #1;
      chk("mid_rst_valids", 64'({awvalid, wvalid, wlast, bready, done_valid, busy, cmd_ready}), 64'(7'd0));
      chk("mid_rst_level", 64'(fifo_level), 64'(0));
      chk("mid_rst_payload", 64'({awid, awaddr, awlen, awsize, awburst}), 64'(0));
      chk("mid_rst_w", 64'({wdata, wstrb, done_id, done_resp, done_id_err}), 64'(0));
      @(posedge aclk);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      step();
      step();
      chk("post_rst_ready", 64'(cmd_ready), 64'(1'b1));
      chk("post_rst_no_done", 64'(done_cnt), 64'(exp_done));
      preload(2);
      run_cmd(32'h700, 4'd4, 8'd1, 3'd1, 2'b01, 4'd4, 2'b00, 0);
      chk("final_done_count", 64'(done_cnt), 64'(exp_done));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_wr_burst_master.md
AXI_WR_BURST_MASTER -- requirements
Module: axi_wr_burst_master

Interface
REQ-001 Parameters (name, default, meaning):
  DATA_WIDTH, 32, W data width in bits; one of 32/64/128.
  ADDR_WIDTH, 32, AW address width.
  ID_WIDTH, 4, AWID/BID width.
  FIFO_DEPTH, 16, write-data buffer depth in entries; power of two, >=2.
  LW = log2(FIFO_DEPTH)+1, derived, width of fifo_level.
REQ-002 Ports (name, direction, width, meaning):
  aclk  in  1  system clock.
  aresetn  in  1  reset, asynchronous, active-low.
  cmd_valid / cmd_ready  in / out  1 / 1  burst command handshake.
  cmd_addr  in  ADDR_WIDTH  start address.
  cmd_id  in  ID_WIDTH  transaction ID.
  cmd_len / cmd_size / cmd_burst  in  8 / 3 / 2  AWLEN / AWSIZE / AWBURST.
  wr_data_valid / wr_data_ready  in / out  1 / 1  data push handshake.
  wr_data / wr_strb  in  DATA_WIDTH / DATA_WIDTH/8  beat payload.
  awvalid / awready  out / in  1 / 1; awid, awaddr, awlen, awsize, awburst  out  ID/ADDR/8/3/2.
  awlock, awcache, awprot, awqos  out  1/4/3/4  tied to 0.
  wvalid / wready  out / in  1 / 1; wdata, wstrb, wlast  out  DATA_WIDTH / DATA_WIDTH/8 / 1.
  bvalid / bready  in / out  1 / 1; bid  in  ID_WIDTH; bresp  in  2.
  done_valid  out  1  one-cycle completion pulse.
  done_id / done_resp / done_id_err  out  ID_WIDTH / 2 / 1  completion status.
  busy  out  1  high when state != IDLE.
  fifo_level  out  LW  buffered beat count.

Function
REQ-003 States: IDLE, BURST, RESP; state register only updated on aclk rising edge.
REQ-004 cmd_ready = 1 only in IDLE; command accepted on cmd_valid && cmd_ready.
REQ-005 Accepted command fields registered; AW outputs driven from registers, never combinationally from cmd_*.
REQ-006 Size check: cmd_size > log2(DATA_WIDTH/8) -> no AW/W issued; done_valid=1 next cycle with done_resp=2'b10, done_id=cmd_id; stay IDLE.
REQ-007 Legal command -> BURST next cycle with awvalid=1; awvalid held with stable payload until awready sampled high, then 0.
REQ-008 In BURST, W issued concurrently with AW (no wait for awready); wvalid = (beats_sent <= awlen) && fifo not empty.
REQ-009 wdata/wstrb = FIFO head; wlast = 1 iff beats_sent == awlen; payload stable while wvalid && !wready.
REQ-010 Beat accepted on wvalid && wready: FIFO pop, beats_sent +1 (9-bit counter; awlen=255 gives 256 beats).
REQ-011 BURST -> RESP once AW accepted and last beat accepted (either order, or same cycle); bready=1 in RESP.
REQ-012 On bvalid && bready: bready=0, done_valid=1 for exactly one cycle, done_resp=bresp, done_id=bid, done_id_err=(bid != awid); -> IDLE.
REQ-013 done_id/done_resp/done_id_err hold until next done_valid.
REQ-014 FIFO: wr_data_ready = !full; push on wr_data_valid && wr_data_ready; pushes accepted in any state.
REQ-015 Full with simultaneous pop: push refused that cycle (ready already low); slot visible next cycle.
REQ-016 Empty with simultaneous push: no bypass; wvalid may rise the following cycle.
REQ-017 fifo_level = pushes - pops, updated each cycle, range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-018 Leftover FIFO beats after a burst are retained for the next command.

Reset
REQ-019 aresetn low: immediately state=IDLE, FIFO emptied, counters 0; awvalid, wvalid, wlast, bready, done_valid, busy = 0; all AW/W/done payload outputs = 0; cmd_ready = 0 while reset asserted, 1 after release.
REQ-020 Reset mid-burst abandons the transaction with no done_valid.

Verification
REQ-021 Push 4 beats, cmd len=3 size=2 addr=0x100 id=5, awready/wready=1, bresp=0 bid=5 -> 4 W beats, wlast on 4th, done_valid once, done_resp=0, done_id_err=0.
REQ-022 wready low 2 cycles mid-burst, awready delayed 5 cycles -> payload stable while stalled; W completes before AW; RESP entered only after AW handshake.
REQ-023 Fill FIFO to FIFO_DEPTH -> wr_data_ready=0, fifo_level=16; pop while pushing -> push refused that cycle, accepted next.
REQ-024 cmd_size=3 with DATA_WIDTH=32 -> no awvalid, done_valid with done_resp=2'b10.
REQ-025 bid=6 for awid=5, bresp=2'b10 -> done_resp=2'b10, done_id=6, done_id_err=1.
REQ-026 Assert aresetn low during BURST -> all outputs 0 asynchronously, fifo_level=0, no done_valid; next command completes normally.
